intbus_axil_bridge: RTL



---
 rtl/intbus_axil_bridge_if.sv | 46 ++++
 rtl/intbus_axil_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/intbus_axil_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : intbus_interf
//  Description : intbus connection between one bus master (the AXI4-Lite
//                bridge) and the register files. Read data and read-valid
//                from all slaves arrive OR-combined on rdata/rvalid.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    addr    master->slave  ADDR_WIDTH  word address
//    wdata   master->slave  DATA_WIDTH  write data
//    wr      master->slave  1           single-cycle write strobe
//    rd      master->slave  1           single-cycle read strobe
//    rdata   slave->master  DATA_WIDTH  OR-combined read data
//    rvalid  slave->master  1           OR-combined read data valid
// ============================================================================
interface intbus_interf #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (
        output addr,
        output wdata,
        output wr,
        output rd,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  addr,
        input  wdata,
        input  wr,
        input  rd,
        output rdata,
        output rvalid
    );
endinterface
`default_nettype wire

// File: rtl/intbus_axil_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : intbus_axil_bridge
//  Description : AXI4-Lite slave to intbus master bridge. Each AXI read or
//                write becomes one single-cycle intbus strobe; reads then
//                wait for the OR-combined rvalid (combinational, flopped or
//                synchronised slaves) with a timeout that always completes
//                the AXI transaction.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1               single clock (also the intbus clock)
//    resetn         in   1               asynchronous active-low reset
//    s_axi_aw*      AXI write address channel
//    s_axi_w*       AXI write data channel
//    s_axi_b*       AXI write response channel
//    s_axi_ar*      AXI read address channel
//    s_axi_r*       AXI read data channel
//    bus            intbus master modport
//    timeout_cnt    out  16              saturating count of read timeouts
// ============================================================================
module intbus_axil_bridge #(
    parameter int                     AXI_ADDR_WIDTH = 18,
    parameter int                     BUS_ADDR_WIDTH = 16,
    parameter int                     DATA_WIDTH     = 32,
    parameter int                     TIMEOUT        = 64,
    parameter logic [DATA_WIDTH-1:0]  TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  wire logic                      clk,
    input  wire logic                      resetn,

    input  wire logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  wire logic                      s_axi_awvalid,
    output logic                           s_axi_awready,

    input  wire logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  wire logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  wire logic                      s_axi_wvalid,
    output logic                           s_axi_wready,

    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  wire logic                      s_axi_bready,

    input  wire logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  wire logic                      s_axi_arvalid,
    output logic                           s_axi_arready,

    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  wire logic                      s_axi_rready,

    intbus_interf.master                   bus,

    output logic [15:0]                    timeout_cnt
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("intbus_axil_bridge: DATA_WIDTH must be 32");
        end
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("intbus_axil_bridge: TIMEOUT must be at least 2");
        end
    endgenerate

    localparam int                      CNT_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]        c_cnt_last  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]        c_cnt_one   = CNT_W'(1);
    localparam logic [1:0]              c_okay      = 2'b00;
    localparam logic [1:0]              c_slverr    = 2'b10;
    localparam logic [DATA_WIDTH/8-1:0] c_full_strb = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_WR_RESP  = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RD_RESP  = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_wr_grant;
    logic                      w_rd_grant;
    logic                      w_capture;
    logic                      w_timeout;

    logic                      r_prio;      // 0: write wins a tie, 1: read wins
    logic [BUS_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    logic [1:0]                r_bresp;
    logic [1:0]                r_rresp;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic [CNT_W-1:0]          r_cnt;
    logic [15:0]               r_timeout_cnt;

    // Only the word-address slice of the AXI addresses reaches intbus.
    wire w_unused_addr_bits = &{1'b0, s_axi_awaddr, s_axi_araddr};

    // ------------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_wr_grant = 1'b0;
        w_rd_grant = 1'b0;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A write needs both AW and W present; ties resolved by r_prio.
                if ((s_axi_awvalid && s_axi_wvalid) && (!s_axi_arvalid || !r_prio)) begin
                    w_wr_grant = 1'b1;
                    w_next     = S_WR_ISSUE;
                end else if (s_axi_arvalid) begin
                    w_rd_grant = 1'b1;
                    w_next     = S_RD_ISSUE;
                end
            end
            S_WR_ISSUE: w_next = S_WR_RESP;
            S_WR_RESP: begin
                if (s_axi_bready) begin
                    w_next = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                // Combinational slaves answer in the strobe cycle itself.
                if (bus.rvalid) begin
                    w_capture = 1'b1;
                    w_next    = S_RD_RESP;
                end else begin
                    w_next    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (bus.rvalid) begin
                    w_capture = 1'b1;
                    w_next    = S_RD_RESP;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout = 1'b1;
                    w_next    = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (s_axi_rready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_prio        <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_bresp       <= c_okay;
            r_rresp       <= c_okay;
            r_rdata       <= '0;
            r_cnt         <= '0;
            r_timeout_cnt <= '0;
        end else begin
            r_state <= w_next;

            if (w_wr_grant) begin
                r_addr  <= s_axi_awaddr[BUS_ADDR_WIDTH+1:2];
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
                r_prio  <= ~r_prio;
            end else if (w_rd_grant) begin
                r_addr  <= s_axi_araddr[BUS_ADDR_WIDTH+1:2];
                r_prio  <= ~r_prio;
            end

            // Sub-word writes cannot be expressed on intbus and are refused.
            if (r_state == S_WR_ISSUE) begin
                r_bresp <= (r_wstrb == c_full_strb) ? c_okay : c_slverr;
            end

            if (r_state == S_RD_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_RD_WAIT) begin
                r_cnt <= r_cnt + c_cnt_one;
            end

            if (w_capture) begin
                r_rdata <= bus.rdata;
                r_rresp <= c_okay;
            end else if (w_timeout) begin
                r_rdata <= TIMEOUT_DATA;
                r_rresp <= c_slverr;
                if (r_timeout_cnt != 16'hFFFF) begin
                    r_timeout_cnt <= r_timeout_cnt + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_axi_awready = w_wr_grant;
    assign s_axi_wready  = w_wr_grant;
    assign s_axi_arready = w_rd_grant;
    assign s_axi_bvalid  = (r_state == S_WR_RESP);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = (r_state == S_RD_RESP);
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign timeout_cnt   = r_timeout_cnt;

    assign bus.addr  = r_addr;
    assign bus.wdata = r_wdata;
    assign bus.wr    = (r_state == S_WR_ISSUE) && (r_wstrb == c_full_strb);
    assign bus.rd    = (r_state == S_RD_ISSUE);

endmodule
`default_nettype wire
